// File: rtl/gemm_tile_mac.sv
// gemm_tile_mac: output-stationary M_TILE x N_TILE signed MAC tile, one outer-product
// K-step per beat, drained row-by-row over a valid/ready stream.
module gemm_tile_mac #(
  parameter int M_TILE    = 4,
  parameter int N_TILE    = 8,
  parameter int A_WIDTH   = 16,
  parameter int B_WIDTH   = 8,
  parameter int ACC_WIDTH = 32,
  parameter int K_MAX     = 256,
  localparam int K_W      = $clog2(K_MAX + 1),
  localparam int R_W      = (M_TILE > 1) ? $clog2(M_TILE) : 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        cfg_start,
  input  logic [K_W-1:0]              cfg_k,
  input  logic                        cfg_accum,
  output logic                        busy,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [M_TILE*A_WIDTH-1:0]   a_vec,
  input  logic [N_TILE*B_WIDTH-1:0]   b_vec,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [R_W-1:0]              out_row,
  output logic [N_TILE*ACC_WIDTH-1:0] out_data,
  output logic                        out_last
);
  localparam int P_W = A_WIDTH + B_WIDTH;
  typedef enum logic [1:0] {IDLE, LOAD, DRAIN} state_e;
  state_e                 state_q, state_d;
  logic [K_W-1:0]         k_q, k_d, cnt_q, cnt_d;
  logic [R_W-1:0]         row_q, row_d;
  logic [ACC_WIDTH-1:0]   acc_q [M_TILE][N_TILE];
  logic [ACC_WIDTH-1:0]   acc_d [M_TILE][N_TILE];
  logic signed [P_W-1:0]  prod  [M_TILE][N_TILE];
  if (ACC_WIDTH < P_W) begin : g_acc_chk
    $error("ACC_WIDTH must be >= A_WIDTH + B_WIDTH");
  end
  // Full-precision signed products; sign extension to ACC_WIDTH happens at the add.
  for (genvar i = 0; i < M_TILE; i++) begin : g_r
    for (genvar j = 0; j < N_TILE; j++) begin : g_c
      assign prod[i][j] = P_W'($signed(a_vec[i*A_WIDTH +: A_WIDTH])) *
                          P_W'($signed(b_vec[j*B_WIDTH +: B_WIDTH]));
    end
  end
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    cnt_d   = cnt_q;
    row_d   = row_q;
    acc_d   = acc_q;
    case (state_q)
      IDLE: if (cfg_start) begin
        k_d     = cfg_k;
        cnt_d   = '0;
        row_d   = '0;
        state_d = (cfg_k == '0) ? DRAIN : LOAD;
        if (!cfg_accum)
          for (int i = 0; i < M_TILE; i++)
            for (int j = 0; j < N_TILE; j++)
              acc_d[i][j] = '0;
      end
      LOAD: if (in_valid) begin
        cnt_d   = cnt_q + K_W'(1);
        state_d = (cnt_q == k_q - K_W'(1)) ? DRAIN : LOAD;
        for (int i = 0; i < M_TILE; i++)
          for (int j = 0; j < N_TILE; j++)
            acc_d[i][j] = acc_q[i][j] + ACC_WIDTH'(prod[i][j]);
      end
      DRAIN: if (out_ready) begin
        row_d   = row_q + R_W'(1);
        state_d = out_last ? IDLE : DRAIN;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      k_q     <= '0;
      cnt_q   <= '0;
      row_q   <= '0;
      for (int i = 0; i < M_TILE; i++)
        for (int j = 0; j < N_TILE; j++)
          acc_q[i][j] <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      cnt_q   <= cnt_d;
      row_q   <= row_d;
      acc_q   <= acc_d;
    end
  assign busy      = state_q != IDLE;
  assign in_ready  = state_q == LOAD;
  assign out_valid = state_q == DRAIN;
  assign out_row   = row_q;
  assign out_last  = out_valid && (row_q == R_W'(M_TILE - 1));
  for (genvar j = 0; j < N_TILE; j++) begin : g_out
    assign out_data[j*ACC_WIDTH +: ACC_WIDTH] = acc_q[row_q][j];
  end
endmodule
